fetch_unit: RTL

- Instruction fetch front end. Owns the PC and issues word requests to instruction memory over a valid/ready interface.
- Buffers in-order responses and presents instruction, pc and pc+4 to decode with a valid/ready handshake; op/funct3/funct7 slices feed the decode controller directly.
- Accepts PC redirects from execute (taken branch, jal, jalr) and discards stale in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_unit_pkg;

  localparam int unsigned ILEN = 32;

  // Instruction field positions consumed by the decode controller
  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;
  // addi x0, x0, 0 -- inserted downstream as a pipeline bubble
  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

  function automatic logic [OP_W-1:0] op_of(input logic [ILEN-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic [FUNCT3_W-1:0] funct3_of(input logic [ILEN-1:0] instr);
    return instr[FUNCT3_LSB +: FUNCT3_W];
  endfunction

  function automatic logic [FUNCT7_W-1:0] funct7_of(input logic [ILEN-1:0] instr);
    return instr[FUNCT7_LSB +: FUNCT7_W];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer; flush wins over a same-cycle push.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  input  logic                             flush,
  output logic [WIDTH-1:0]                 head,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The credit scheme upstream must never push into a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(do_push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC ownership, credit-limited request issue, response
// buffering toward decode and redirect handling with stale-response drop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned       DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_pc4,
  output logic [6:0]       id_op,
  output logic [2:0]       id_funct3,
  output logic [6:0]       id_funct7,
  output logic             misalign_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = CW + 1;
  localparam int unsigned EW = ILEN + XLEN;

  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] rsp_pc, rsp_pc_nxt;
  logic [CW-1:0]   outstanding, out_nxt;
  logic [CW-1:0]   drop_cnt, drop_nxt;
  logic [CW-1:0]   count;
  logic [IW-1:0]   inflight;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic            empty;
  logic [EW-1:0]   head;

  // Credit check: in-flight requests plus buffered entries never exceed DEPTH
  assign inflight       = IW'(outstanding) + IW'(count);
  assign imem_req_valid = !reset && (inflight < IW'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a pre-reset request
  assign rsp_fire     = imem_rsp_valid && (outstanding != '0);
  assign push         = rsp_fire && (drop_cnt == '0) && !redirect_valid;
  assign pop          = id_valid && id_ready;
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // Next-state for pc, response pc and the outstanding/drop counters
  always_comb begin
    pc_nxt     = pc;
    rsp_pc_nxt = rsp_pc;
    out_nxt    = outstanding + CW'(req_fire) - CW'(rsp_fire);
    drop_nxt   = drop_cnt;
    if (redirect_valid) begin
      // Everything still in flight after this cycle fetched the old path
      pc_nxt     = redirect_tgt;
      rsp_pc_nxt = redirect_tgt;
      drop_nxt   = out_nxt;
    end else begin
      if (req_fire) pc_nxt = pc + XLEN'(4);
      if (push)     rsp_pc_nxt = rsp_pc + XLEN'(4);
      if (rsp_fire && (drop_cnt != '0)) drop_nxt = drop_cnt - CW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      rsp_pc       <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      rsp_pc       <= rsp_pc_nxt;
      outstanding  <= out_nxt;
      drop_cnt     <= drop_nxt;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  // Decode-side view of the buffer head
  assign id_valid  = !reset && !empty;
  assign id_instr  = head[EW-1:XLEN];
  assign id_pc     = head[XLEN-1:0];
  assign id_pc4    = id_pc + XLEN'(4);
  assign id_op     = op_of(id_instr);
  assign id_funct3 = funct3_of(id_instr);
  assign id_funct7 = funct7_of(id_instr);

endmodule
